// File: rtl/imem_port_arbiter_if.sv
// rtl/imem_port_arbiter_if.sv - fetch, loader and memory-side signals of the imem port arbiter
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
        output fetch_gnt, fetch_valid, fetch_data, ld_ready, ld_done, busy,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data, mem_rdata,
        input  fetch_gnt, fetch_valid, fetch_data, ld_ready, ld_done, busy,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - round-robin sharing of byte-wide instruction memory between fetch and loader
module imem_port_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_port_arbiter_if.slave   bus
);
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    localparam logic GNT_FETCH  = 1'b0;
    localparam logic GNT_LOADER = 1'b1;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic [31:0]       fetch_data_q, fetch_data_d;
    logic              ld_done_q, ld_done_d;
    logic              busy_q, busy_d;

    logic              fetch_gnt;
    logic              ld_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              win_fetch;
    logic              win_ld;

    // On a tie the requester that was not served last time wins.
    assign win_fetch = bus.fetch_req && (!bus.ld_valid || (last_grant_q == GNT_LOADER));
    assign win_ld    = bus.ld_valid  && (!bus.fetch_req || (last_grant_q == GNT_FETCH));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        base_d        = base_q;
        data_d        = data_q;
        fetch_data_d  = fetch_data_q;
        fetch_gnt     = 1'b0;
        ld_ready      = 1'b0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        mem_wdata     = '0;

        // Combinational outputs must read zero while reset is held.
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (win_fetch) begin
                        fetch_gnt    = 1'b1;
                        mem_addr     = bus.fetch_addr[ADDR_W-1:0];
                        fetch_data_d = bus.mem_rdata;
                        last_grant_d = GNT_FETCH;
                    end else if (win_ld) begin
                        ld_ready     = 1'b1;
                        base_d       = {bus.ld_addr[ADDR_W-1:2], 2'b00};
                        data_d       = bus.ld_data;
                        last_grant_d = GNT_LOADER;
                        cnt_d        = 2'd0;
                        state_d      = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    mem_we   = 1'b1;
                    mem_addr = base_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                    case (cnt_q)
                        2'd0:    mem_wdata = data_q[31:24];
                        2'd1:    mem_wdata = data_q[23:16];
                        2'd2:    mem_wdata = data_q[15:8];
                        default: mem_wdata = data_q[7:0];
                    endcase
                    if (cnt_q == 2'd3) begin
                        cnt_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        fetch_valid_d = fetch_gnt;
        // Registered so that the pulse lands in the cycle whose write uses cnt=3.
        ld_done_d     = (state_q == ST_WRITE) && (cnt_q == 2'd2);
        busy_d        = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 2'd0;
            last_grant_q  <= GNT_LOADER;
            base_q        <= '0;
            data_q        <= '0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            ld_done_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            base_q        <= base_d;
            data_q        <= data_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_data_q  <= fetch_data_d;
            ld_done_q     <= ld_done_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.fetch_gnt   = fetch_gnt;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.ld_ready    = ld_ready;
    assign bus.ld_done     = ld_done_q;
    assign bus.busy        = busy_q;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_we      = mem_we;
    assign bus.mem_wdata   = mem_wdata;
endmodule
